// File: rtl/csa_adder_pipe.sv
// csa_adder_pipe: two-stage pipelined carry-select adder/subtractor.
//
// Stage 1 computes each BLOCK-bit slice sum for both possible carry-ins
// (block 0 uses the real effective carry-in). Stage 2 resolves the
// block carries through a 2:1 select chain and picks the block results.
// Computes S = A + (B ^ {WIDTH{sub}}) + (cin ^ sub), so sub=1, cin=0
// gives A - B with cout = 1 meaning no borrow.
//
// Parameters:
//   WIDTH     operand/result width, a multiple of BLOCK, >= 2*BLOCK
//   BLOCK     carry-select block width
// Ports:
//   Clk       rising-edge clock
//   Reset     asynchronous active-high reset, empties the pipeline
//   in_valid  A, B, cin, sub are valid this cycle
//   in_ready  operands accepted this cycle (combinational, from out_ready)
//   A, B      operands
//   cin       carry-in
//   sub       1 = subtract
//   out_valid S, cout, ovf hold a valid result
//   out_ready consumer takes the result this cycle
//   S         registered sum/difference
//   cout      registered carry out of the MSB
//   ovf       registered two's-complement overflow
module csa_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NB = WIDTH / BLOCK;

  // handshake state
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic adv1;
  logic accept;

  // stage 1 combinational
  logic [WIDTH-1:0]          be;
  logic                      ce;
  logic [BLOCK-1:0]          b0_sum;
  logic                      b0_c;
  logic [NB-1:1][BLOCK-1:0]  s0;
  logic [NB-1:1][BLOCK-1:0]  s1;
  logic [NB-1:1]             c0;
  logic [NB-1:1]             c1;

  // stage 1 registers
  logic [BLOCK-1:0]          b0_sum_q;
  logic                      b0_c_q;
  logic [NB-1:1][BLOCK-1:0]  s0_q;
  logic [NB-1:1][BLOCK-1:0]  s1_q;
  logic [NB-1:1]             c0_q;
  logic [NB-1:1]             c1_q;
  logic                      a_msb_q;
  logic                      be_msb_q;

  // stage 2 combinational
  logic [WIDTH-1:0]          s_next;
  logic                      k;
  logic                      ovf_next;

  assign s2_free   = !s2_valid || out_ready;
  assign adv1      = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_comb begin
    be     = B ^ {WIDTH{sub}};
    ce     = cin ^ sub;
    s0     = '0;
    s1     = '0;
    c0     = '0;
    c1     = '0;
    {b0_c, b0_sum} = {1'b0, A[BLOCK-1:0]} + {1'b0, be[BLOCK-1:0]}
                   + (BLOCK+1)'(ce);
    for (int unsigned i = 1; i < NB; i++) begin
      {c0[i], s0[i]} = {1'b0, A[i*BLOCK +: BLOCK]} + {1'b0, be[i*BLOCK +: BLOCK]};
      {c1[i], s1[i]} = {1'b0, A[i*BLOCK +: BLOCK]} + {1'b0, be[i*BLOCK +: BLOCK]}
                     + (BLOCK+1)'(1);
    end
  end

  // k walks the select chain: on entry to iteration i it is the carry into block i.
  always_comb begin
    s_next               = '0;
    k                    = b0_c_q;
    s_next[BLOCK-1:0]    = b0_sum_q;
    for (int unsigned i = 1; i < NB; i++) begin
      s_next[i*BLOCK +: BLOCK] = k ? s1_q[i] : s0_q[i];
      k                        = k ? c1_q[i] : c0_q[i];
    end
    ovf_next = (a_msb_q == be_msb_q) && (s_next[WIDTH-1] != a_msb_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      b0_sum_q <= '0;
      b0_c_q   <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      c0_q     <= '0;
      c1_q     <= '0;
      a_msb_q  <= 1'b0;
      be_msb_q <= 1'b0;
      S        <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        b0_sum_q <= b0_sum;
        b0_c_q   <= b0_c;
        s0_q     <= s0;
        s1_q     <= s1;
        c0_q     <= c0;
        c1_q     <= c1;
        a_msb_q  <= A[WIDTH-1];
        be_msb_q <= be[WIDTH-1];
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end

      // When stage 2 can take data it mirrors stage 1 occupancy; an empty
      // stage 1 with out_ready high therefore drains the output.
      if (s2_free) begin
        s2_valid <= s1_valid;
      end

      if (adv1) begin
        S    <= s_next;
        cout <= k;
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_csa_adder_pipe.sv
module tb_csa_adder_pipe;

  logic        Clk;
  logic        Reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic        sub;

  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] S16;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  S8;
  logic        in_ready32, out_valid32, cout32, ovf32;
  logic [31:0] S32;

  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  csa_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready16),
    .A(A[15:0]), .B(B[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready),
    .S(S16), .cout(cout16), .ovf(ovf16)
  );

  csa_adder_pipe #(.WIDTH(8), .BLOCK(2)) dut8 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready8),
    .A(A[7:0]), .B(B[7:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .S(S8), .cout(cout8), .ovf(ovf8)
  );

  csa_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready32),
    .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready),
    .S(S32), .cout(cout32), .ovf(ovf32)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic; overflow = true signed result out of range.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    longint unsigned mask, au, bu, tot;
    longint half, sa, sbe, st;
    logic o, c;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(64'd1 << (w - 1));
    au   = 64'(a) & mask;
    bu   = (sb ? ~64'(b) : 64'(b)) & mask;
    tot  = au + bu + 64'(ci ^ sb);
    sa   = (longint'(au) >= half) ? longint'(au) - 2 * half : longint'(au);
    sbe  = (longint'(bu) >= half) ? longint'(bu) - 2 * half : longint'(bu);
    st   = sa + sbe + longint'(ci ^ sb);
    o    = (st > half - 1) || (st < -half);
    c    = ((tot >> w) & 64'd1) != 0;
    return {o, c, 32'(tot & mask)};
  endfunction

  task automatic mon(input int k, input int w, input logic rdy, input logic vld,
                     input logic [31:0] s, input logic c, input logic o, input string nm);
    int n;
    logic [33:0] e;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    check({nm, " in_ready"}, 64'(rdy), 64'((n < 2) || out_ready));
    if (vld && out_ready) begin
      if (n == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s spurious: got out_valid=1, expected no result pending", nm);
      end else begin
        case (k)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check({nm, " {ovf,cout,S}"}, 64'({o, c, s}), 64'(e));
      end
    end
    if (in_valid && rdy) begin
      e = model(w, A, B, cin, sub);
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    @(negedge Clk);
    A = 32'(v.a); B = 32'(v.b); cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({nm, " in_ready"}, 64'(in_ready16), 64'(1));
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    check({nm, " out_valid after 1 edge"}, 64'(out_valid16), 64'(0));
    @(posedge Clk);
    @(negedge Clk);
    check({nm, " out_valid"}, 64'(out_valid16), 64'(1));
    check({nm, " S"},    64'(S16),    64'(v.s));
    check({nm, " cout"}, 64'(cout16), 64'(v.cout));
    check({nm, " ovf"},  64'(ovf16),  64'(v.ovf));
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; cin = 1'b0; sub = 1'b0;
  endtask

  initial begin
    int acc;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset out_valid", 64'(out_valid16), 64'(0));
    check("reset S",         64'(S16),         64'(0));
    check("reset cout",      64'(cout16),      64'(0));
    check("reset ovf",       64'(ovf16),       64'(0));
    @(negedge Clk);
    Reset = 1'b0;
    #1 check("after reset in_ready", 64'(in_ready16), 64'(1));

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: three ops with out_ready low, then release.
    @(negedge Clk);
    out_ready = 1'b0; in_valid = 1'b1; put(32'd1, 32'd1);
    #1 check("bp accept1 in_ready", 64'(in_ready16), 64'(1));
    @(negedge Clk);
    put(32'd2, 32'd2);
    #1 check("bp accept2 in_ready", 64'(in_ready16), 64'(1));
    @(negedge Clk);
    put(32'd3, 32'd3);
    #1 check("bp full in_ready", 64'(in_ready16), 64'(0));
    check("bp full out_valid", 64'(out_valid16), 64'(1));
    check("bp full S", 64'(S16), 64'(16'h0002));
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1 check("bp stall in_ready", 64'(in_ready16), 64'(0));
      check("bp stall S", 64'(S16), 64'(16'h0002));
    end
    @(negedge Clk);
    out_ready = 1'b1;
    #1 check("bp release in_ready", 64'(in_ready16), 64'(1));
    check("bp out1 valid", 64'(out_valid16), 64'(1));
    check("bp out1 S", 64'(S16), 64'(16'h0002));
    @(negedge Clk);
    in_valid = 1'b0;
    check("bp out2 valid", 64'(out_valid16), 64'(1));
    check("bp out2 S", 64'(S16), 64'(16'h0004));
    @(negedge Clk);
    check("bp out3 valid", 64'(out_valid16), 64'(1));
    check("bp out3 S", 64'(S16), 64'(16'h0006));
    @(negedge Clk);
    check("bp drained out_valid", 64'(out_valid16), 64'(0));

    // Asynchronous reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1; put(32'hC000, 32'h8000);
    @(negedge Clk);
    put(32'h0011, 32'h0022);
    @(negedge Clk);
    in_valid = 1'b0;
    check("pre-reset S", 64'(S16), 64'(16'h4000));
    check("pre-reset in_ready", 64'(in_ready16), 64'(0));
    #2 Reset = 1'b1;
    #1 check("async reset out_valid", 64'(out_valid16), 64'(0));
    check("async reset S",    64'(S16),    64'(0));
    check("async reset cout", 64'(cout16), 64'(0));
    check("async reset ovf",  64'(ovf16),  64'(0));
    @(negedge Clk);
    Reset = 1'b0; out_ready = 1'b1;
    #1 check("post-reset in_ready", 64'(in_ready16), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("post-reset no ghost", 64'(out_valid16), 64'(0));
    end
    run_op(vecs[4], "post-reset op");

    // Randomized run on all three configurations.
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
      @(negedge Clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A = $urandom; B = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
      #1;
      if (in_valid && in_ready16) acc++;
      mon(0, 16, in_ready16, out_valid16, 32'(S16), cout16, ovf16, "w16");
      mon(1, 8,  in_ready8,  out_valid8,  32'(S8),  cout8,  ovf8,  "w8");
      mon(2, 32, in_ready32, out_valid32, S32,      cout32, ovf32, "w32");
    end
    check("random accept budget", 64'(acc), 64'(10000));
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      mon(0, 16, in_ready16, out_valid16, 32'(S16), cout16, ovf16, "w16");
      mon(1, 8,  in_ready8,  out_valid8,  32'(S8),  cout8,  ovf8,  "w8");
      mon(2, 32, in_ready32, out_valid32, S32,      cout32, ovf32, "w32");
    end
    check("w16 results outstanding", 64'(q0.size()), 64'(0));
    check("w8 results outstanding",  64'(q1.size()), 64'(0));
    check("w32 results outstanding", 64'(q2.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
